// File: rtl/regs_wb_sched_pkg.sv
// Shared widths, requester indices and helpers for the write-back scheduler.
package regs_wb_sched_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int NUM_REQ    = 3;

    localparam int REQ_EX  = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

    typedef logic [NUM_REQ-1:0]  grant_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    function automatic reg_mask_t reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        reg_mask_t m;
        m       = '0;
        m[addr] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/regs_wb_sched_wb_starve_cnt.sv
// Saturating wait counter for one write-back requester; flags starvation once
// the requester has waited STARVE_MAX cycles without a grant.
module wb_starve_cnt #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic grant,
    output logic starving
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!valid || grant) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign starving = (cnt >= CNT_W'(STARVE_MAX));
endmodule

// File: rtl/regs_wb_sched.sv
// Write-back scheduler: arbitrates EX/LSU/MDU results onto the register file's
// single write port and keeps a busy scoreboard for long-latency destinations.
module regs_wb_sched
    import regs_wb_sched_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [REG_ADDR_W-1:0] ex_waddr_i,
    input  logic [XLEN-1:0]       ex_wdata_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [REG_ADDR_W-1:0] lsu_waddr_i,
    input  logic [XLEN-1:0]       lsu_wdata_i,
    input  logic                  mdu_valid_i,
    output logic                  mdu_ready_o,
    input  logic [REG_ADDR_W-1:0] mdu_waddr_i,
    input  logic [XLEN-1:0]       mdu_wdata_i,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    output logic                  hazard_o,
    output logic                  reg_wen_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o,
    output logic [XLEN-1:0]       reg_wdata_o,
    output logic [NUM_REGS-1:0]   busy_o
);
    // Handshake: a result moves when valid and ready are both high in the same
    // cycle; a requester holding valid without ready keeps waddr/wdata stable.
    grant_t                grant;
    logic                  lsu_starving;
    logic                  mdu_starving;
    logic                  transfer;
    logic [REG_ADDR_W-1:0] sel_waddr;
    logic [XLEN-1:0]       sel_wdata;
    reg_mask_t             busy_q;
    reg_mask_t             busy_d;
    reg_mask_t             set_mask;
    reg_mask_t             clr_mask;

    wb_starve_cnt #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_lsu_cnt (
        .clk      (clk),
        .rst      (rst),
        .valid    (lsu_valid_i),
        .grant    (grant[REQ_LSU]),
        .starving (lsu_starving)
    );

    wb_starve_cnt #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_mdu_cnt (
        .clk      (clk),
        .rst      (rst),
        .valid    (mdu_valid_i),
        .grant    (grant[REQ_MDU]),
        .starving (mdu_starving)
    );

    // Starving requesters outrank EX; readies stay low while reset is held.
    always_comb begin
        grant = '0;
        if (!rst) begin
            grant = '0;
        end else if (lsu_valid_i && lsu_starving) begin
            grant[REQ_LSU] = 1'b1;
        end else if (mdu_valid_i && mdu_starving) begin
            grant[REQ_MDU] = 1'b1;
        end else if (ex_valid_i) begin
            grant[REQ_EX] = 1'b1;
        end else if (lsu_valid_i) begin
            grant[REQ_LSU] = 1'b1;
        end else if (mdu_valid_i) begin
            grant[REQ_MDU] = 1'b1;
        end
    end

    assign ex_ready_o  = grant[REQ_EX];
    assign lsu_ready_o = grant[REQ_LSU];
    assign mdu_ready_o = grant[REQ_MDU];
    assign transfer    = |grant;

    always_comb begin
        sel_waddr = '0;
        sel_wdata = '0;
        if (grant[REQ_EX]) begin
            sel_waddr = ex_waddr_i;
            sel_wdata = ex_wdata_i;
        end else if (grant[REQ_LSU]) begin
            sel_waddr = lsu_waddr_i;
            sel_wdata = lsu_wdata_i;
        end else if (grant[REQ_MDU]) begin
            sel_waddr = mdu_waddr_i;
            sel_wdata = mdu_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
        end else if (transfer) begin
            reg_wen_o   <= (sel_waddr != '0);
            reg_waddr_o <= sel_waddr;
            reg_wdata_o <= sel_wdata;
        end else begin
            reg_wen_o   <= 1'b0;
        end
    end

    // Only LSU/MDU writes retire a busy bit; an issue to the same index wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid_i) begin
            set_mask = reg_onehot(issue_rd_i);
        end
        if (grant[REQ_LSU] || grant[REQ_MDU]) begin
            clr_mask = reg_onehot(sel_waddr);
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o   = busy_q;
    assign hazard_o = busy_q[id_rs1_i] | busy_q[id_rs2_i] | busy_q[id_rd_i];
endmodule

// File: tb/tb_regs_wb_sched.sv
// Directed bench for regs_wb_sched: expected write-port outputs are queued when
// a transfer is expected and compared one edge later.
module tb_regs_wb_sched;
    import regs_wb_sched_pkg::*;

    localparam int W = 1 + REG_ADDR_W + XLEN;

    logic                  clk;
    logic                  rst;
    logic                  ex_valid_i, lsu_valid_i, mdu_valid_i;
    logic                  ex_ready_o, lsu_ready_o, mdu_ready_o;
    logic [REG_ADDR_W-1:0] ex_waddr_i, lsu_waddr_i, mdu_waddr_i;
    logic [XLEN-1:0]       ex_wdata_i, lsu_wdata_i, mdu_wdata_i;
    logic                  issue_valid_i;
    logic [REG_ADDR_W-1:0] issue_rd_i, id_rs1_i, id_rs2_i, id_rd_i;
    logic                  hazard_o;
    logic                  reg_wen_o;
    logic [REG_ADDR_W-1:0] reg_waddr_o;
    logic [XLEN-1:0]       reg_wdata_o;
    logic [NUM_REGS-1:0]   busy_o;

    logic [W-1:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    regs_wb_sched dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid_i    (ex_valid_i),
        .ex_ready_o    (ex_ready_o),
        .ex_waddr_i    (ex_waddr_i),
        .ex_wdata_i    (ex_wdata_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_waddr_i   (lsu_waddr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .mdu_valid_i   (mdu_valid_i),
        .mdu_ready_o   (mdu_ready_o),
        .mdu_waddr_i   (mdu_waddr_i),
        .mdu_wdata_i   (mdu_wdata_i),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rd_i       (id_rd_i),
        .hazard_o      (hazard_o),
        .reg_wen_o     (reg_wen_o),
        .reg_waddr_o   (reg_waddr_o),
        .reg_wdata_o   (reg_wdata_o),
        .busy_o        (busy_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        ex_valid_i    = 1'b0;
        lsu_valid_i   = 1'b0;
        mdu_valid_i   = 1'b0;
        issue_valid_i = 1'b0;
    endtask

    // Called at posedge+1 with inputs driven: checks readies, queues the
    // expected write, crosses one edge and checks the write port.
    task automatic cycle(input string tag, input logic ge, input logic gl, input logic gm);
        logic [W-1:0] e;
        logic [W-1:0] got;
        #2;
        chk({tag, "_ready"}, {61'd0, ex_ready_o, lsu_ready_o, mdu_ready_o}, {61'd0, ge, gl, gm});
        if (ge) exp_q.push_back({ex_waddr_i != 5'd0, ex_waddr_i, ex_wdata_i});
        else if (gl) exp_q.push_back({lsu_waddr_i != 5'd0, lsu_waddr_i, lsu_wdata_i});
        else if (gm) exp_q.push_back({mdu_waddr_i != 5'd0, mdu_waddr_i, mdu_wdata_i});
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {reg_wen_o, reg_waddr_o, reg_wdata_o};
            chk({tag, "_wr"}, 64'(got), 64'(e));
        end else begin
            chk({tag, "_nowen"}, 64'(reg_wen_o), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        ex_waddr_i = '0; ex_wdata_i = '0;
        lsu_waddr_i = '0; lsu_wdata_i = '0;
        mdu_waddr_i = '0; mdu_wdata_i = '0;
        issue_rd_i = '0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // traffic before a mid-run reset
        ex_valid_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'h1234;
        issue_valid_i = 1'b1; issue_rd_i = 5'd4;
        cycle("pre", 1, 0, 0);
        chk("pre_busy", 64'(busy_o), 64'h10);

        // asynchronous reset while requests are pending
        rst = 1'b0;
        ex_waddr_i = 5'd6; lsu_valid_i = 1'b1; lsu_waddr_i = 5'd8;
        id_rs1_i = 5'd4;
        #1;
        chk("rst_out", {reg_wen_o, reg_waddr_o, reg_wdata_o}, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ready", {ex_ready_o, lsu_ready_o, mdu_ready_o}, 64'd0);
        chk("rst_hazard", 64'(hazard_o), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_hold", {reg_wen_o, reg_waddr_o, reg_wdata_o, busy_o}, 64'd0);
        rst = 1'b1;
        idle_inputs();
        id_rs1_i = 5'd0;
        ex_valid_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'hDEADBEEF;
        cycle("post_rst", 1, 0, 0);

        // fixed priority with EX busy for two cycles
        ex_valid_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'h11;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd2; lsu_wdata_i = 32'h22;
        mdu_valid_i = 1'b1; mdu_waddr_i = 5'd3; mdu_wdata_i = 32'h33;
        cycle("pri_t0", 1, 0, 0);
        ex_wdata_i = 32'h12;
        cycle("pri_t1", 1, 0, 0);
        ex_valid_i = 1'b0;
        cycle("pri_t2", 0, 1, 0);
        lsu_valid_i = 1'b0;
        cycle("pri_t3", 0, 0, 1);
        mdu_valid_i = 1'b0;
        cycle("pri_idle", 0, 0, 0);

        // LSU starvation against continuous EX
        ex_valid_i = 1'b1; ex_waddr_i = 5'd10;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd11; lsu_wdata_i = 32'h55;
        for (int i = 0; i < 6; i++) begin
            ex_wdata_i  = $urandom();
            lsu_valid_i = (i <= 4);
            cycle($sformatf("starve_t%0d", i), i != 4, i == 4, 1'b0);
        end

        // both starving: LSU first, then MDU still beats EX
        lsu_valid_i = 1'b1; lsu_wdata_i = 32'h66;
        mdu_valid_i = 1'b1; mdu_waddr_i = 5'd13; mdu_wdata_i = 32'h77;
        for (int i = 0; i < 7; i++) begin
            ex_wdata_i  = $urandom_range(0, 32'hFFFF);
            lsu_valid_i = (i <= 4);
            mdu_valid_i = (i <= 5);
            cycle($sformatf("both_t%0d", i), i < 4 || i == 6, i == 4, i == 5);
        end
        idle_inputs();

        // scoreboard set, hazard and MDU clear
        issue_valid_i = 1'b1; issue_rd_i = 5'd7; id_rs1_i = 5'd7;
        cycle("sb_issue", 0, 0, 0);
        issue_valid_i = 1'b0;
        chk("sb_busy_set", 64'(busy_o), 64'h80);
        chk("sb_hazard", 64'(hazard_o), 64'd1);
        repeat (3) cycle("sb_wait", 0, 0, 0);
        mdu_valid_i = 1'b1; mdu_waddr_i = 5'd7; mdu_wdata_i = 32'h7777;
        #1;
        chk("sb_hazard_grant", 64'(hazard_o), 64'd1);
        cycle("sb_clear", 0, 0, 1);
        mdu_valid_i = 1'b0;
        chk("sb_busy_clr", 64'(busy_o), 64'd0);
        chk("sb_hazard_clr", 64'(hazard_o), 64'd0);
        id_rs1_i = 5'd0;

        // set wins over a same-cycle clear
        issue_valid_i = 1'b1; issue_rd_i = 5'd9; id_rs2_i = 5'd9;
        cycle("sim_pre", 0, 0, 0);
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd9; lsu_wdata_i = 32'h99;
        cycle("sim_both", 0, 1, 0);
        issue_valid_i = 1'b0;
        chk("sim_busy", 64'(busy_o), 64'h200);
        chk("sim_hazard", 64'(hazard_o), 64'd1);
        lsu_wdata_i = 32'h9A;
        cycle("sim_clr", 0, 1, 0);
        lsu_valid_i = 1'b0;
        chk("sim_busy_clr", 64'(busy_o), 64'd0);
        id_rs2_i = 5'd0;

        // WAW hazard, then EX write to a busy register leaves it busy
        issue_valid_i = 1'b1; issue_rd_i = 5'd12; id_rd_i = 5'd12;
        cycle("waw_issue", 0, 0, 0);
        issue_valid_i = 1'b0;
        chk("waw_hazard", 64'(hazard_o), 64'd1);
        ex_valid_i = 1'b1; ex_waddr_i = 5'd12; ex_wdata_i = 32'hC0;
        cycle("waw_ex", 1, 0, 0);
        ex_valid_i = 1'b0;
        chk("waw_busy_kept", 64'(busy_o), 64'h1000);
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd12; lsu_wdata_i = 32'hC1;
        cycle("waw_lsu", 0, 1, 0);
        lsu_valid_i = 1'b0;
        chk("waw_busy_clr", 64'(busy_o), 64'd0);
        id_rd_i = 5'd0;

        // x0 is never tracked and never written
        issue_valid_i = 1'b1; issue_rd_i = 5'd0;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd0; lsu_wdata_i = 32'hAB;
        cycle("x0", 0, 1, 0);
        idle_inputs();
        chk("x0_busy", 64'(busy_o), 64'd0);
        chk("x0_hazard", 64'(hazard_o), 64'd0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/regs_wb_sched.md
Name: regs_wb_sched

Overview:
- Write-back scheduler for the 32x32 register file's single write port.
- Arbitrates three result producers onto the file's reg_wen/reg_waddr_i/reg_wdata_i inputs:
  - EX: single-cycle ALU results.
  - LSU: load data.
  - MDU: multi-cycle mul/div results.
- Keeps a busy-bit scoreboard of destinations owed by LSU/MDU and raises a hazard stall to ID.
- Sits between EX/LSU/MDU and regs; ID reads the scoreboard.

Parameters:
- STARVE_MAX, 4: wait cycles after which a valid LSU/MDU request preempts EX; range 1..15.
- CNT_W, 4: width of each starvation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ex_valid_i  in  1  EX result valid.
- ex_ready_o  out  1  EX result accepted this cycle.
- ex_waddr_i  in  5  EX destination register.
- ex_wdata_i  in  32  EX result.
- lsu_valid_i  in  1  LSU load result valid.
- lsu_ready_o  out  1  LSU result accepted.
- lsu_waddr_i  in  5  LSU destination register.
- lsu_wdata_i  in  32  LSU result.
- mdu_valid_i  in  1  MDU result valid.
- mdu_ready_o  out  1  MDU result accepted.
- mdu_waddr_i  in  5  MDU destination register.
- mdu_wdata_i  in  32  MDU result.
- issue_valid_i  in  1  ID issues a long-latency (LSU/MDU) instruction.
- issue_rd_i  in  5  its destination register.
- id_rs1_i  in  5  ID source 1 address.
- id_rs2_i  in  5  ID source 2 address.
- id_rd_i  in  5  ID destination address (WAW check).
- hazard_o  out  1  ID must stall.
- reg_wen_o  out  1  to regs reg_wen.
- reg_waddr_o  out  5  to regs reg_waddr_i.
- reg_wdata_o  out  32  to regs reg_wdata_i.
- busy_o  out  32  scoreboard vector, for debug.

Behaviour:
- Reset (rst=0, async): reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0, busy=0, both starvation counters=0. hazard_o and ready outputs follow from the cleared state.
- Grant is combinational; ready_o is asserted for exactly one valid requester per cycle, else none.
- Priority: EX > LSU > MDU.
- Preemption: a starving requester outranks EX. LSU starving beats MDU starving.
- Starving means counter >= STARVE_MAX.
- Counter behaviour:
  - Increments (saturating at 2^CNT_W-1) while valid and not granted.
  - Clears on grant or when valid is low.
- Handshake: a transfer occurs when valid & ready in the same cycle. Requesters hold waddr/wdata stable while valid & !ready.
- Output stage, 1-cycle latency:
  - On a transfer, the next edge registers reg_waddr_o/reg_wdata_o from the granted source.
  - reg_wen_o=1 only if waddr != 0.
  - No transfer: reg_wen_o=0; addr/data hold.
- Scoreboard:
  - issue_valid_i with issue_rd_i != 0 sets busy[issue_rd_i] at the next edge.
  - An LSU or MDU transfer clears busy[waddr] at the next edge.
  - Set and clear on the same index in the same cycle: set wins.
  - busy[0] is always 0.
- hazard_o = busy[id_rs1_i] | busy[id_rs2_i] | busy[id_rd_i], combinational; x0 is never hazardous.
  - A register whose clearing write is granted this cycle still reads busy this cycle. It deasserts the cycle the registered write reaches regs; regs forwarding covers that cycle.
- EX transfer to a busy register: the scoreboard is unchanged, and the write still occurs. Prevention is ID's job via hazard_o.
- Reset mid-operation: pending handshakes are dropped; requesters re-present after reset.

Decomposition:
- Shared package:
  - REG_ADDR_W=5 and XLEN=32.
  - Requester index constants: REQ_EX=0, REQ_LSU=1, REQ_MDU=2.
- One sub-module, wb_starve_cnt: the saturating wait counter with starving flag, instantiated twice (LSU, MDU).
- Arbiter, scoreboard and output register stay in the top.

Test Plan:
- Reset: hold rst=0 mid-traffic -> all outputs 0, busy_o=0. Release -> first EX write x5=0xDEADBEEF shows reg_wen_o=1, reg_waddr_o=5 one cycle after the handshake.
- Priority: EX(x1=0x11), LSU(x2=0x22), MDU(x3=0x33) all valid at t0, EX continuous for 2 cycles. Expected:
  - ex_ready_o=1 at t0 and t1.
  - LSU granted at t2 (counter reaches 2 < 4, EX idle at t2).
  - MDU granted at t3.
- Starvation: EX valid every cycle, LSU valid from t0 -> lsu_ready_o=1 at t4 and ex_ready_o=0 at t4; EX resumes at t5.
- Scoreboard: issue x7 at t0 -> busy_o[7]=1 at t1. id_rs1_i=7 -> hazard_o=1. MDU writes x7 at t5 -> busy_o[7]=0 and hazard_o=0 at t6.
- Simultaneous set/clear: at t0 the LSU clears x9 while ID issues x9 -> busy_o[9]=1 at t1.
- x0: issue x0 and LSU write x0 -> busy_o=0, handshake completes, reg_wen_o=0; id_rs2_i=0 never raises hazard_o.
